tx_fifo_ctrl_module: RTL and testbench

TX_FIFO_CTRL_MODULE -- requirements
Module: tx_fifo_ctrl_module

---
 rtl/tx_fifo_ctrl_module_pkg.sv | 27 ++
 rtl/tx_fifo_ctrl_module_if.sv | 43 ++++
 rtl/tx_fifo_mem.sv | 42 ++++
 rtl/tx_fifo_ctrl_module.sv | 121 ++++++++++++
 tb/tb_tx_fifo_ctrl_module.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_fifo_ctrl_module_pkg.sv
//============================================================================
// Module      : tx_fifo_ctrl_module_pkg
// Description : Shared UART package. Holds the transmit data width, the
//               default TX FIFO geometry and the state encodings of the
//               FIFO-to-transmitter sequencing FSM.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package tx_fifo_ctrl_module_pkg;

    // Existing TX constants
    localparam int c_TX_DATA_W = 8;

    // Default FIFO geometry (c_DEFAULT_AW must equal log2(c_DEFAULT_DEPTH))
    localparam int c_DEFAULT_DEPTH = 16;
    localparam int c_DEFAULT_AW    = 4;

    // Sequencing FSM encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/tx_fifo_ctrl_module_if.sv
//============================================================================
// Module      : tx_fifo_ctrl_module_if
// Description : Bus bundle between the producer / UART transmit stage and
//               the TX FIFO controller.
//   wr_en, wr_data   : producer byte-write strobe and data
//   full, empty      : FIFO level flags
//   count            : stored byte count (AW+1 bits)
//   overflow, ovf_clr: sticky dropped-write flag and its clear
//   tx_en_sig,tx_data: enable and byte towards the transmit stage
//   tx_done          : one-cycle completion pulse from the transmit stage
//   Modport slave is taken by the controller, master by its environment.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface tx_fifo_ctrl_module_if
    import tx_fifo_ctrl_module_pkg::*;
#(
    parameter int AW = c_DEFAULT_AW
);
    logic                   wr_en;
    logic [c_TX_DATA_W-1:0] wr_data;
    logic                   full;
    logic                   empty;
    logic [AW:0]            count;
    logic                   overflow;
    logic                   ovf_clr;
    logic                   tx_en_sig;
    logic [c_TX_DATA_W-1:0] tx_data;
    logic                   tx_done;

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_done,
        output full, empty, count, overflow, tx_en_sig, tx_data
    );

    modport master (
        output wr_en, wr_data, ovf_clr, tx_done,
        input  full, empty, count, overflow, tx_en_sig, tx_data
    );
endinterface

`default_nettype wire

// File: rtl/tx_fifo_mem.sv
//============================================================================
// Module      : tx_fifo_mem
// Description : Single-clock dual-port byte array, DEPTH entries.
//               Synchronous write port, combinational read port.
//   clk       : system clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write byte
//   i_rd_addr : read address
//   o_rd_data : byte at i_rd_addr (combinational)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tx_fifo_mem
    import tx_fifo_ctrl_module_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int AW    = c_DEFAULT_AW
) (
    input  wire logic                   clk,
    input  wire logic                   i_wr_en,
    input  wire logic [AW-1:0]          i_wr_addr,
    input  wire logic [c_TX_DATA_W-1:0] i_wr_data,
    input  wire logic [AW-1:0]          i_rd_addr,
    output logic      [c_TX_DATA_W-1:0] o_rd_data
);

    // Contents are intentionally not reset
    logic [c_TX_DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/tx_fifo_ctrl_module.sv
//============================================================================
// Module      : tx_fifo_ctrl_module
// Description : Byte FIFO in front of a UART transmit stage. Producer writes
//               are queued; an IDLE/LOAD/SEND/GAP sequencer pops one byte
//               at a time, holds it on tx_data with tx_en_sig high until
//               tx_done, then idles one cycle so the downstream bit counter
//               restarts cleanly.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : tx_fifo_ctrl_module_if.slave (write side, flags, TX side)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tx_fifo_ctrl_module
    import tx_fifo_ctrl_module_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int AW    = c_DEFAULT_AW
) (
    input  wire logic              clk,
    input  wire logic              rst,
    tx_fifo_ctrl_module_if.slave   bus
);

    localparam logic [AW:0]   c_FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   r_overflow;
    logic                   r_tx_en;
    logic [c_TX_DATA_W-1:0] r_tx_data;
    logic [c_TX_DATA_W-1:0] w_rd_data;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_acc;
    logic                   w_pop;

    // Flags come from the registered count so pointer wrap never matters
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = bus.wr_en & ~w_full;
    // IDLE only enters LOAD when non-empty, so LOAD always has a byte
    assign w_pop    = (r_state == c_ST_LOAD);

    tx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc & ~rst),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (!w_empty)   w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:                 w_state_nxt = c_ST_SEND;
            c_ST_SEND: if (bus.tx_done) w_state_nxt = c_ST_GAP;
            c_ST_GAP:                  w_state_nxt = c_ST_IDLE;
            default:                   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Registered enable, high exactly while the FSM sits in SEND
            r_tx_en <= (w_state_nxt == c_ST_SEND);

            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end

            if (w_pop) begin
                r_tx_data <= w_rd_data;
                r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
            end

            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            // A dropped write outranks a simultaneous clear
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.tx_en_sig = r_tx_en;
    assign bus.tx_data   = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_tx_fifo_ctrl_module.sv
//============================================================================
// Module      : tb_tx_fifo_ctrl_module
// Description : Self-checking bench for tx_fifo_ctrl_module. A cycle table
//               covers reset and the single-byte transfer; hand sequences
//               cover fill/overflow, simultaneous write+pop, reset during
//               SEND and a 40-byte stream through a tx_done sink model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_tx_fifo_ctrl_module;
    import tx_fifo_ctrl_module_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int N_VEC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_fifo_ctrl_module_if #(.AW(AW)) bus();

    tx_fifo_ctrl_module #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic td_dir  = 1'b0;
    logic td_sink = 1'b0;
    assign bus.tx_done = td_dir | td_sink;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        td_dir      = 1'b0;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       ovf_clr;
        logic       tx_done;
        logic [4:0] e_count;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_txen;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl [N_VEC];

    // tx_done sink: after 20 cycles of tx_en_sig, check the byte and pulse
    logic       sink_en  = 1'b0;
    int         sink_cyc = 0;
    int         rx_cnt   = 0;
    logic [7:0] exp_q [$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sink_en && bus.tx_en_sig) begin
                sink_cyc++;
                if (sink_cyc == 20) begin
                    if (exp_q.size() == 0) begin
                        chk("stream extra byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
                    end else begin
                        chk("stream byte order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                    end
                    rx_cnt++;
                    td_sink  = 1'b1;
                    sink_cyc = 0;
                end else begin
                    td_sink = 1'b0;
                end
            end else begin
                td_sink = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int guard;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;

        // rst wr  data  clr done | cnt full empty ovf txen data
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}; // reset
        tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // write
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // IDLE sees data
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5}; // LOAD -> SEND
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5}; // SEND holds
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5}; // tx_done -> GAP
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5}; // IDLE
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5}; // stray tx_done
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5}; // still idle
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5}; // clr when clear

        for (int i = 0; i < N_VEC; i++) begin
            rst         = tbl[i].rst;
            bus.wr_en   = tbl[i].wr_en;
            bus.wr_data = tbl[i].wr_data;
            bus.ovf_clr = tbl[i].ovf_clr;
            td_dir      = tbl[i].tx_done;
            step();
            chk($sformatf("vec%0d count", i),     32'(bus.count),     32'(tbl[i].e_count));
            chk($sformatf("vec%0d full", i),      32'(bus.full),      32'(tbl[i].e_full));
            chk($sformatf("vec%0d empty", i),     32'(bus.empty),     32'(tbl[i].e_empty));
            chk($sformatf("vec%0d overflow", i),  32'(bus.overflow),  32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d tx_en_sig", i), 32'(bus.tx_en_sig), 32'(tbl[i].e_txen));
            chk($sformatf("vec%0d tx_data", i),   32'(bus.tx_data),   32'(tbl[i].e_data));
        end
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        td_dir      = 1'b0;

        // Fill: 16 back-to-back writes, byte 00 is popped on the way,
        // so one more write reaches full; the write after that overflows.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            step();
        end
        chk("fill count after 16", 32'(bus.count),     32'd15);
        chk("fill tx_data",        32'(bus.tx_data),   32'h00);
        chk("fill tx_en_sig",      32'(bus.tx_en_sig), 32'd1);
        chk("fill not full yet",   32'(bus.full),      32'd0);
        bus.wr_data = 8'h10;
        step();
        chk("full count",  32'(bus.count), 32'd16);
        chk("full flag",   32'(bus.full),  32'd1);
        chk("full no ovf", 32'(bus.overflow), 32'd0);
        // Dropped write coinciding with ovf_clr: set wins
        bus.wr_data = 8'hEE;
        bus.ovf_clr = 1'b1;
        step();
        chk("ovf set wins",      32'(bus.overflow), 32'd1);
        chk("ovf count kept",    32'(bus.count),    32'd16);
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        step();
        chk("ovf sticky",        32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        chk("ovf cleared",       32'(bus.overflow), 32'd0);
        chk("ovf clr count",     32'(bus.count),    32'd16);
        chk("data held in SEND", 32'(bus.tx_data),  32'h00);

        // Write and pop in the same cycle at count=5
        do_reset();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h11;
        step();
        bus.wr_en = 1'b0;
        step();
        step();
        chk("wp first SEND", 32'(bus.tx_en_sig), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h21 + i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("wp count 5", 32'(bus.count), 32'd5);
        td_dir = 1'b1;
        step();
        td_dir = 1'b0;
        chk("wp GAP tx_en low", 32'(bus.tx_en_sig), 32'd0);
        step();
        chk("wp IDLE tx_en low", 32'(bus.tx_en_sig), 32'd0);
        step();
        chk("wp LOAD tx_en low", 32'(bus.tx_en_sig), 32'd0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h26;
        step();
        bus.wr_en = 1'b0;
        chk("wp count stays 5", 32'(bus.count),     32'd5);
        chk("wp tx_en_sig",     32'(bus.tx_en_sig), 32'd1);
        chk("wp tx_data",       32'(bus.tx_data),   32'h21);

        // Reset while in SEND with three bytes queued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'hC0 + i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("rs pre count",   32'(bus.count),     32'd3);
        chk("rs pre tx_en",   32'(bus.tx_en_sig), 32'd1);
        chk("rs pre tx_data", 32'(bus.tx_data),   32'hC0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs tx_en low",  32'(bus.tx_en_sig), 32'd0);
        chk("rs count",      32'(bus.count),     32'd0);
        chk("rs empty",      32'(bus.empty),     32'd1);
        chk("rs tx_data",    32'(bus.tx_data),   32'h00);
        step();
        step();
        chk("rs stays idle", 32'(bus.tx_en_sig), 32'd0);

        // 40-byte stream across pointer wraps
        do_reset();
        sink_en = 1'b1;
        sent    = 0;
        guard   = 0;
        while ((sent < 40 || rx_cnt < 40) && guard < 4000) begin
            if (sent < 40 && !bus.full) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'(sent * 7 + 3);
                exp_q.push_back(8'(sent * 7 + 3));
                sent++;
            end else begin
                bus.wr_en = 1'b0;
            end
            step();
            guard++;
        end
        bus.wr_en = 1'b0;
        sink_en   = 1'b0;
        chk("stream finished in budget", 32'(guard < 4000), 32'd1);
        chk("stream rx count",  32'(rx_cnt),       32'd40);
        chk("stream queue empty", 32'(exp_q.size()), 32'd0);
        step();
        step();
        chk("stream end empty", 32'(bus.empty),    32'd1);
        chk("stream no ovf",    32'(bus.overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
